// File: rtl/mux_sync_pkg.sv
// Shared types and default constants for the mux-synchronizer transmit sequencer.
package mux_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } xfer_state_e;

  localparam int MUX_SYNC_DEF_FLOPS   = 2;
  localparam int MUX_SYNC_DEF_SETUP   = 1;
  localparam int MUX_SYNC_DEF_TIMEOUT = 1024;

endpackage

// File: rtl/synchronize_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset.
module synchronize_bit #(
  parameter int NUM_OF_SYNC_FLOPS = 2
) (
  input  logic dest_clk,
  input  logic rstn,
  input  logic D_in,
  output logic D_out
);

  logic [NUM_OF_SYNC_FLOPS-1:0] sync_q;

  always_ff @(posedge dest_clk or negedge rstn) begin
    if (!rstn) begin
      sync_q[0] <= 1'b0;
    end else begin
      sync_q[0] <= D_in;
    end
  end

  for (genvar gi = 1; gi < NUM_OF_SYNC_FLOPS; gi++) begin : g_stage
    always_ff @(posedge dest_clk or negedge rstn) begin
      if (!rstn) begin
        sync_q[gi] <= 1'b0;
      end else begin
        sync_q[gi] <= sync_q[gi-1];
      end
    end
  end

  assign D_out = sync_q[NUM_OF_SYNC_FLOPS-1];

endmodule

// File: rtl/mux_sync_tx_ctrl.sv
// Source-side sequencer for a mux-synchronized bus: holds the word, raises xfer_req, runs a
// 4-phase handshake on the synchronized ack. Optional REQ abort built with MUX_SYNC_TX_TIMEOUT_EN.
module mux_sync_tx_ctrl
  import mux_sync_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_OF_SYNC_FLOPS = MUX_SYNC_DEF_FLOPS,
  parameter int SETUP_CYCLES      = MUX_SYNC_DEF_SETUP,
  parameter int TIMEOUT_CYCLES    = MUX_SYNC_DEF_TIMEOUT
) (
  input  logic                  src_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  xfer_req,
  input  logic                  xfer_ack,
  output logic                  busy,
  output logic                  timeout
);

  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);

  xfer_state_e           state_q;
  logic                  in_ready_q;
  logic [DATA_WIDTH-1:0] xfer_data_q;
  logic                  xfer_req_q;
  logic [SETUP_W-1:0]    setup_cnt_q;
  logic [SETUP_W-1:0]    setup_cnt_d;
  logic                  ack_s;
  logic                  rstn;

  assign rstn = ~rst;

  synchronize_bit #(
    .NUM_OF_SYNC_FLOPS(NUM_OF_SYNC_FLOPS)
  ) u_ack_sync (
    .dest_clk(src_clk),
    .rstn    (rstn),
    .D_in    (xfer_ack),
    .D_out   (ack_s)
  );

  assign setup_cnt_d = setup_cnt_q + 1'b1;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            timeout_q;

  assign to_cnt_d = to_cnt_q + 1'b1;
  assign timeout  = timeout_q;
`else
  // Keeps the timeout parameter referenced when the abort logic is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      xfer_data_q <= '0;
      xfer_req_q  <= 1'b0;
      setup_cnt_q <= '0;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef MUX_SYNC_TX_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          // in_ready_q is low only for the first cycle out of reset
          if (in_valid && in_ready_q) begin
            xfer_data_q <= in_data;
            in_ready_q  <= 1'b0;
            setup_cnt_q <= '0;
            state_q     <= SETUP;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (setup_cnt_q == SETUP_LAST) begin
            xfer_req_q <= 1'b1;
            state_q    <= REQ;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
          end else begin
            setup_cnt_q <= setup_cnt_d;
          end
        end
        REQ: begin
          // ack is tested first so it wins over an expiring timeout
          if (ack_s) begin
            xfer_req_q <= 1'b0;
            state_q    <= RELEASE;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
          end else if (to_cnt_d == TO_LIMIT) begin
            xfer_req_q <= 1'b0;
            timeout_q  <= 1'b1;
            state_q    <= RELEASE;
          end else begin
            to_cnt_q <= to_cnt_d;
`endif
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign xfer_data = xfer_data_q;
  assign xfer_req  = xfer_req_q;
  assign busy      = (state_q != IDLE);

endmodule
